// File: rtl/candy_mem_resp.sv
// Memory-side responder: word-addressed storage with byte-masked writes and a
// wait-stated read channel that answers with a single-cycle rdata_ready pulse.
module candy_mem_resp #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_enable,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_ready,
  output logic                  busy,
  input  logic                  write_enable,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                accept;
  logic [DATA_W-1:0]   fwd_word;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign accept = (state_q == S_IDLE) && read_enable && armed_q;

  // A write landing on the response edge at the captured address must be seen
  // by this read, so merge it byte-wise in front of the storage read.
  always_comb begin
    fwd_word = mem_q[addr_q];
    for (int b = 0; b < STRB_W; b++) begin
      if (write_enable && (waddr == addr_q) && wstrb[b]) begin
        fwd_word[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = raddr;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = fwd_word;
          rdy_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A level held high yields one response; it must drop before the next read.
  always_comb begin
    armed_d = armed_q;
    if (!read_enable) begin
      armed_d = 1'b1;
    end else if (accept) begin
      armed_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      addr_q  <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive rst, and reset
  // only blocks the write on that edge.
  always_ff @(posedge clk) begin
    if (!rst && write_enable) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata       = rdata_q;
  assign rdata_ready = rdy_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_candy_mem_resp.sv
// Self-checking bench for candy_mem_resp: a WAIT_CYCLES=2 and a WAIT_CYCLES=0
// instance share stimulus; a word-array model supplies every expected value.
module tb_candy_mem_resp;

  logic        clk;
  logic        rst;
  logic        read_enable;
  logic [9:0]  raddr;
  logic        write_enable;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic [31:0] rdata2, rdata0;
  logic        rdy2, rdy0, busy2, busy0;

  bit          use0;
  logic [31:0] rdata_s;
  logic        rdy_s, busy_s;

  logic [31:0] ref_mem [1024];
  int          errors;
  int          checks;

  candy_mem_resp #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .read_enable(read_enable), .raddr(raddr),
    .rdata(rdata2), .rdata_ready(rdy2), .busy(busy2),
    .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
  );

  candy_mem_resp #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .read_enable(read_enable), .raddr(raddr),
    .rdata(rdata0), .rdata_ready(rdy0), .busy(busy0),
    .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
  );

  assign rdata_s = use0 ? rdata0 : rdata2;
  assign rdy_s   = use0 ? rdy0   : rdy2;
  assign busy_s  = use0 ? busy0  : busy2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // One clock edge; the model applies the write the DUT saw on that edge.
  task automatic step();
    logic        we;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    we = write_enable && !rst;
    a  = waddr;
    d  = wdata;
    s  = wstrb;
    @(posedge clk);
    #1;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    write_enable = 1'b1;
    waddr        = a;
    wdata        = d;
    wstrb        = s;
    step();
    write_enable = 1'b0;
  endtask

  // Read of address a; coll_k is the edge offset from accept at which a write
  // to a is driven (-1 for none); rnd adds random writes on the other edges.
  task automatic do_read(input logic [9:0] a, input int coll_k, input logic [31:0] cd,
                         input logic [3:0] cs, input bit rnd, input string tag);
    logic [31:0] exp_d;
    int          w;
    w     = use0 ? 0 : 2;
    exp_d = '0;
    for (int k = 0; k <= w + 2; k++) begin
      read_enable  = (k == 0);
      raddr        = a;
      write_enable = 1'b0;
      if (k == coll_k) begin
        write_enable = 1'b1;
        waddr        = a;
        wdata        = cd;
        wstrb        = cs;
      end else if (rnd && $urandom_range(1, 0) == 1) begin
        write_enable = 1'b1;
        waddr        = ($urandom_range(1, 0) == 1) ? a : 10'($urandom);
        wdata        = $urandom;
        wstrb        = 4'($urandom);
      end
      step();
      if (k <= w) begin
        checks++;
        if (rdy_s !== 1'b0 || busy_s !== 1'b1) begin
          errors++;
          $display("FAIL %s wait k=%0d: rdy=%b busy=%b, required rdy=0 busy=1", tag, k, rdy_s, busy_s);
        end
      end else if (k == w + 1) begin
        exp_d = ref_mem[a];
        checks++;
        if (rdy_s !== 1'b1 || busy_s !== 1'b1 || rdata_s !== exp_d) begin
          errors++;
          $display("FAIL %s resp: rdy=%b busy=%b rdata=%h, required rdy=1 busy=1 rdata=%h",
                   tag, rdy_s, busy_s, rdata_s, exp_d);
        end
      end else begin
        checks++;
        if (rdy_s !== 1'b0 || busy_s !== 1'b0 || rdata_s !== exp_d) begin
          errors++;
          $display("FAIL %s after: rdy=%b busy=%b rdata=%h, required rdy=0 busy=0 rdata=%h",
                   tag, rdy_s, busy_s, rdata_s, exp_d);
        end
      end
    end
    write_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (rdata2 !== 32'h0 || rdy2 !== 1'b0 || busy2 !== 1'b0 ||
        rdata0 !== 32'h0 || rdy0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset: w2 rdata=%h rdy=%b busy=%b w0 rdata=%h rdy=%b busy=%b, required all 0",
               rdata2, rdy2, busy2, rdata0, rdy0, busy0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 1024; i++) do_write(10'(i), $urandom, 4'hF);
  endtask

  task automatic test_basic();
    do_write(10'h010, 32'hDEADBEEF, 4'hF);
    do_read(10'h010, -1, 32'h0, 4'h0, 1'b0, "basic");
    checks++;
    if (rdata_s !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic value: rdata=%h, required deadbeef", rdata_s);
    end
  endtask

  task automatic test_hold();
    int pulses;
    pulses      = 0;
    read_enable = 1'b1;
    raddr       = 10'h010;
    repeat (20) begin
      step();
      if (rdy_s === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL hold pulses: got %0d, required 1", pulses);
    end
    read_enable = 1'b0;
    step();
    do_read(10'h011, -1, 32'h0, 4'h0, 1'b0, "hold_rearm");
  endtask

  task automatic test_byte_mask();
    do_write(10'h020, 32'h11223344, 4'hF);
    do_write(10'h020, 32'hAABBCCDD, 4'b0101);
    do_read(10'h020, -1, 32'h0, 4'h0, 1'b0, "bytemask");
    checks++;
    if (rdata_s !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL bytemask value: rdata=%h, required 11bb33dd", rdata_s);
    end
  endtask

  task automatic test_collision();
    do_write(10'h030, 32'h0, 4'hF);
    do_read(10'h030, 3, 32'h12345678, 4'hF, 1'b0, "coll_entry");
    checks++;
    if (rdata_s !== 32'h12345678) begin
      errors++;
      $display("FAIL coll_entry value: rdata=%h, required 12345678", rdata_s);
    end
    do_write(10'h030, 32'h0, 4'hF);
    do_read(10'h030, 4, 32'h12345678, 4'hF, 1'b0, "coll_late");
    checks++;
    if (rdata_s !== 32'h0) begin
      errors++;
      $display("FAIL coll_late value: rdata=%h, required 00000000", rdata_s);
    end
    do_write(10'h031, 32'hA5A5A5A5, 4'hF);
    do_read(10'h031, 3, 32'h5A5A5A5A, 4'b1001, 1'b0, "coll_partial");
  endtask

  task automatic test_reset_mid_read();
    int pulses;
    pulses = 0;
    do_write(10'h055, 32'hCAFEF00D, 4'hF);
    read_enable = 1'b1;
    raddr       = 10'h055;
    step();
    read_enable = 1'b0;
    step();
    rst          = 1'b1;
    write_enable = 1'b1;
    waddr        = 10'h055;
    wdata        = 32'h0BAD0BAD;
    wstrb        = 4'hF;
    step();
    checks++;
    if (rdy_s !== 1'b0 || busy_s !== 1'b0 || rdata_s !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: rdy=%b busy=%b rdata=%h, required 0 0 00000000", rdy_s, busy_s, rdata_s);
    end
    step();
    rst          = 1'b0;
    write_enable = 1'b0;
    repeat (5) begin
      step();
      if (rdy_s !== 1'b0 || busy_s !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_abort: %0d cycles with activity, required 0", pulses);
    end
    do_read(10'h055, -1, 32'h0, 4'h0, 1'b0, "rst_preserve");
    checks++;
    if (rdata_s !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rst_preserve value: rdata=%h, required cafef00d", rdata_s);
    end
  endtask

  task automatic test_random(input int n, input string tag);
    int w;
    w = use0 ? 0 : 2;
    for (int i = 0; i < n; i++) begin
      do_read(10'($urandom), $urandom_range(w + 3, 0) - 1, $urandom, 4'($urandom), 1'b1, tag);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] q[$];
    logic [9:0] a;
    logic [31:0] exp_d;
    bit          exp_rdy;
    read_enable = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 9; k++) begin
      read_enable = (k % 3 != 1);
      if (k % 3 == 0) begin
        a     = 10'($urandom);
        raddr = a;
        q.push_back(a);
      end
      step();
      exp_rdy = (k % 3 == 1);
      checks++;
      if (rdy_s !== exp_rdy) begin
        errors++;
        $display("FAIL b2b pulse k=%0d: rdy=%b, required %b", k, rdy_s, exp_rdy);
      end
      if (exp_rdy && q.size() > 0) begin
        exp_d = ref_mem[q.pop_front()];
        checks++;
        if (rdata_s !== exp_d) begin
          errors++;
          $display("FAIL b2b data k=%0d: rdata=%h, required %h", k, rdata_s, exp_d);
        end
      end
    end
    read_enable = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    use0         = 1'b0;
    rst          = 1'b1;
    read_enable  = 1'b0;
    raddr        = '0;
    write_enable = 1'b0;
    waddr        = '0;
    wdata        = '0;
    wstrb        = '0;

    test_reset();
    test_fill();
    test_basic();
    test_hold();
    test_byte_mask();
    test_collision();
    test_reset_mid_read();
    test_random(30, "rand_w2");

    use0 = 1'b1;
    read_enable = 1'b0;
    repeat (6) step();
    do_read(10'h010, -1, 32'h0, 4'h0, 1'b0, "w0_basic");
    test_random(20, "rand_w0");
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
